// File: rtl/fwd_hazard_pipe.sv
// Purpose: ID-stage hazard detection with per-source forwarding select for EXE; optional FWD_HAZARD_STALL_CNT_EN adds stall_count.
// Latency: stall is combinational from ID and tracking state; exe_sel is registered one advance after ID evaluation.
// Backpressure: advance=0 freezes all state; stall holds IF/ID and inserts a bubble into T[0].
module fwd_hazard_pipe #(
  parameter int REG_AW    = 4,
  parameter int NUM_SRC   = 3,
  parameter int FWD_DEPTH = 2,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
  input  logic                        flush,
  input  logic                        forward_en,
  input  logic                        id_valid,
  input  logic                        id_wb_en,
  input  logic                        id_mem_read,
  input  logic [REG_AW-1:0]           id_dest,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  output logic                        stall,
  output logic [NUM_SRC*SEL_W-1:0]    exe_sel
`ifdef FWD_HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic [REG_AW-1:0] dest;
  } trk_t;

  // trk[0] is EXE; trk[FWD_DEPTH] is writing the register file and is never checked.
  trk_t trk [FWD_DEPTH+1];

  logic [NUM_SRC-1:0]       lu_hit;
  logic [NUM_SRC-1:0]       any_hit;
  logic [NUM_SRC*SEL_W-1:0] sel_nxt;
  logic                     accept;

  always_comb begin
    lu_hit  = '0;
    any_hit = '0;
    sel_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Walk oldest to youngest so the youngest hit overwrites the select.
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (id_valid && id_src_used[i] && trk[j].valid && trk[j].wb_en &&
            trk[j].dest == id_src[i*REG_AW +: REG_AW]) begin
          any_hit[i] = 1'b1;
          if (j == 0 && trk[0].mem_read)
            lu_hit[i] = 1'b1;
          sel_nxt[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
        end
      end
    end
  end

  assign stall  = id_valid && !flush && (forward_en ? |lu_hit : |any_hit);
  assign accept = !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= FWD_DEPTH; j++)
        trk[j] <= '0;
      exe_sel <= '0;
    end else if (advance) begin
      for (int j = 0; j < FWD_DEPTH; j++)
        trk[j+1] <= trk[j];
      if (accept) begin
        trk[0]  <= '{valid: id_valid, wb_en: id_wb_en, mem_read: id_mem_read, dest: id_dest};
        exe_sel <= forward_en ? sel_nxt : '0;
      end else begin
        trk[0]  <= '0;
        exe_sel <= '0;
      end
    end
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (advance && stall && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
